// File: rtl/line_memory.sv
// Line-wide backing store for the direct-mapped cache: one request at a time,
// answered LATENCY cycles after acceptance with a single-cycle readyM pulse.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module line_memory #(
   parameter int WORD_SIZE   = `WORD_SIZE,
   parameter int READ_SIZE   = 4*WORD_SIZE,
   parameter int DEPTH_LINES = 64,
   parameter int LATENCY     = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 readM,
   input  logic                 writeM,
   input  logic [WORD_SIZE-1:0] address,
   inout  wire  [READ_SIZE-1:0] dataM,
   output logic                 readyM,
   output logic                 busy
);
   localparam int         IDX_W    = $clog2(DEPTH_LINES);
   localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 op_wr_q, op_wr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [READ_SIZE-1:0] mem_q [DEPTH_LINES];
   logic                 req;
   logic                 drive_rd;
   logic                 commit_wr;

   // Word-select bits and bits above the index are deliberately dropped (aliasing).
   wire unused_addr_bits = ^{address[WORD_SIZE-1:IDX_W+2], address[1:0]};

   assign req = readM | writeM;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               op_wr_d = writeM;
               idx_d   = address[IDX_W+1:2];
               if (LATENCY == 1) begin
                  state_d = ST_DONE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_BUSY: begin
            if (!req) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
      end
   end

   assign readyM = (state_q == ST_DONE);
   assign busy   = (state_q == ST_BUSY) || (state_q == ST_DONE);

   // A write commits only if still requested and not reset at the edge ending DONE.
   assign drive_rd  = (state_q == ST_DONE) && !op_wr_q && readM && !writeM;
   assign commit_wr = (state_q == ST_DONE) && op_wr_q && writeM && reset_n;

   assign dataM = drive_rd ? mem_q[idx_q] : {READ_SIZE{1'bz}};

   always_ff @(posedge clk) begin
      if (commit_wr) begin
         mem_q[idx_q] <= dataM;
      end
   end

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: table of line requests plus hand-written multi-cycle
// sequences (back-to-back, abort, address change, reset in DONE, LATENCY=1).
module tb_line_memory;
   localparam int W   = 16;
   localparam int RS  = 64;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          readM, writeM;
   logic [W-1:0]  address;
   wire  [RS-1:0] dataM;
   logic [RS-1:0] tb_data;
   logic          tb_drive;
   logic          readyM, busy;

   logic          readM1, writeM1;
   logic [W-1:0]  address1;
   wire  [RS-1:0] dataM1;
   logic [RS-1:0] tb_data1;
   logic          tb_drive1;
   logic          readyM1, busy1;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic          sb_en    = 1'b0;
   logic [RS:0]   exp_q[$];

   typedef struct packed {
      logic          wr;
      logic          rd;
      logic [W-1:0]  addr;
      logic [RS-1:0] data;
   } vec_t;
   vec_t vecs[12];

   always #5 clk = ~clk;

   // The bench parks the bus at its own value; any DUT drive shows up as a changed bus.
   assign dataM  = tb_drive  ? tb_data  : {RS{1'bz}};
   assign dataM1 = tb_drive1 ? tb_data1 : {RS{1'bz}};

   line_memory #(.WORD_SIZE(W), .READ_SIZE(RS), .DEPTH_LINES(64), .LATENCY(LAT)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .readM   (readM),
      .writeM  (writeM),
      .address (address),
      .dataM   (dataM),
      .readyM  (readyM),
      .busy    (busy)
   );

   line_memory #(.WORD_SIZE(W), .READ_SIZE(RS), .DEPTH_LINES(64), .LATENCY(1)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .readM   (readM1),
      .writeM  (writeM1),
      .address (address1),
      .dataM   (dataM1),
      .readyM  (readyM1),
      .busy    (busy1)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Scoreboard: every readyM pulse consumes one expected entry; reads compare the line.
   always @(negedge clk) begin
      logic [RS:0] e;
      if (sb_en && readyM) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_readyM: got pulse with empty queue at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (!e[RS]) chk("read_data", dataM, e[RS-1:0]);
         end
      end
   end

   task automatic tick(input logic exp_rdy, input logic exp_busy, input string tag);
      @(negedge clk);
      chk({tag, "_readyM"}, 64'(readyM), 64'(exp_rdy));
      chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
      if (tb_drive) chk({tag, "_bus"}, dataM, tb_data);
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input logic wr, input logic rd, input logic [W-1:0] addr,
                          input logic [RS-1:0] data, input logic [W-1:0] alt_addr);
      writeM   = wr;
      readM    = rd;
      address  = addr;
      tb_data  = wr ? data : '0;
      tb_drive = 1'b1;
      exp_q.push_back({wr, data});
      for (int k = 0; k <= LAT; k++) begin
         if (k == 2) address = alt_addr;
         if (k == LAT && !wr) tb_drive = 1'b0;
         tick(k == LAT, k >= 1, "req");
      end
      readM    = 1'b0;
      writeM   = 1'b0;
      tb_drive = 1'b1;
      tb_data  = '0;
      tick(1'b0, 1'b0, "req_idle");
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 16'h0014, 64'h1111_2222_3333_4444};
      vecs[1]  = '{1'b0, 1'b1, 16'h0017, 64'h1111_2222_3333_4444};
      vecs[2]  = '{1'b1, 1'b0, 16'h0008, 64'h5555_6666_7777_8888};
      vecs[3]  = '{1'b1, 1'b0, 16'h0104, 64'h0123_4567_89AB_CDEF};
      vecs[4]  = '{1'b0, 1'b1, 16'h0004, 64'h0123_4567_89AB_CDEF};
      vecs[5]  = '{1'b1, 1'b0, 16'h000C, 64'hDEAD_BEEF_CAFE_F00D};
      vecs[6]  = '{1'b1, 1'b0, 16'hFFFC, 64'h7E57_0063_A5A5_5A5A};
      vecs[7]  = '{1'b0, 1'b1, 16'h00FF, 64'h7E57_0063_A5A5_5A5A};
      vecs[8]  = '{1'b1, 1'b0, 16'h0010, 64'h0F0F_0F0F_0F0F_0F0F};
      vecs[9]  = '{1'b1, 1'b1, 16'h0010, 64'hF0F0_F0F0_F0F0_F0F0};
      vecs[10] = '{1'b0, 1'b1, 16'h0012, 64'hF0F0_F0F0_F0F0_F0F0};
      vecs[11] = '{1'b0, 1'b1, 16'h000A, 64'h5555_6666_7777_8888};

      readM = 1'b0; writeM = 1'b0; address = '0; tb_data = '0; tb_drive = 1'b1;
      readM1 = 1'b0; writeM1 = 1'b0; address1 = '0; tb_data1 = '0; tb_drive1 = 1'b1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tick(1'b0, 1'b0, "reset");
      reset_n = 1'b1;
      sb_en   = 1'b1;
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "idle");

      for (int i = 0; i < 12; i++)
         run_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].addr);

      // Back-to-back reads with readM held: pulses in cycles 4 and 9.
      readM   = 1'b1;
      address = 16'h0014;
      exp_q.push_back({1'b0, 64'h1111_2222_3333_4444});
      exp_q.push_back({1'b0, 64'h1111_2222_3333_4444});
      for (int k = 0; k < 10; k++) begin
         tb_drive = !(k == 4 || k == 9);
         tick(k == 4 || k == 9, k != 0 && k != 5, "b2b");
      end
      readM    = 1'b0;
      tb_drive = 1'b1;
      tick(1'b0, 1'b0, "b2b_end");

      // Abort: write to line 2 dropped in cycle 2.
      writeM  = 1'b1;
      address = 16'h0008;
      tb_data = 64'hAAAA_AAAA_AAAA_AAAA;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            writeM  = 1'b0;
            tb_data = '0;
         end
         tick(1'b0, k == 1 || k == 2, "abort");
      end
      run_req(1'b0, 1'b1, 16'h0008, 64'h5555_6666_7777_8888, 16'h0008);

      // Address moved in cycle 2 of a read: latched line 5 still returned.
      run_req(1'b0, 1'b1, 16'h0014, 64'h1111_2222_3333_4444, 16'h0008);

      // Reset during DONE of a write: no commit, readyM low afterwards.
      writeM  = 1'b1;
      address = 16'h000C;
      tb_data = 64'h9999_9999_9999_9999;
      exp_q.push_back({1'b1, 64'h9999_9999_9999_9999});
      for (int k = 0; k < LAT; k++) tick(1'b0, k >= 1, "rst_done");
      reset_n = 1'b0;
      tick(1'b1, 1'b1, "rst_in_done");
      reset_n = 1'b1;
      writeM  = 1'b0;
      tb_data = '0;
      tick(1'b0, 1'b0, "rst_after");
      run_req(1'b0, 1'b1, 16'h000C, 64'hDEAD_BEEF_CAFE_F00D, 16'h000C);

      // LATENCY=1 instance: readyM in cycle 1.
      writeM1  = 1'b1;
      address1 = 16'h0020;
      tb_data1 = 64'h1357_9BDF_2468_ACE0;
      @(negedge clk);
      chk("l1_wr_c0_readyM", 64'(readyM1), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("l1_wr_c1_readyM", 64'(readyM1), 64'd1);
      chk("l1_wr_c1_busy", 64'(busy1), 64'd1);
      @(posedge clk); #1;
      writeM1  = 1'b0;
      tb_data1 = '0;
      @(negedge clk);
      chk("l1_wr_c2_readyM", 64'(readyM1), 64'd0);
      @(posedge clk); #1;
      readM1   = 1'b1;
      address1 = 16'h0022;
      @(negedge clk);
      chk("l1_rd_c0_readyM", 64'(readyM1), 64'd0);
      chk("l1_rd_c0_bus", dataM1, 64'd0);
      @(posedge clk); #1;
      tb_drive1 = 1'b0;
      @(negedge clk);
      chk("l1_rd_c1_readyM", 64'(readyM1), 64'd1);
      chk("l1_rd_c1_data", dataM1, 64'h1357_9BDF_2468_ACE0);
      @(posedge clk); #1;
      readM1    = 1'b0;
      tb_drive1 = 1'b1;
      @(negedge clk);
      chk("l1_rd_c2_readyM", 64'(readyM1), 64'd0);
      chk("l1_rd_c2_bus", dataM1, 64'd0);

      chk("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
